// File: rtl/alu_operand_sequencer_if.sv
// Bus between the button/switch conditioning logic, the operand sequencer and the lab ALU.
// result_valid is a level, not a handshake: high means result_q/flags_q hold a capture for the current A/B/OpCode.
interface alu_operand_sequencer_if #(
  parameter int M = 7
);
  logic [M-1:0] data_in;
  logic         load;
  logic         undo;
  logic [M-1:0] alu_result;
  logic [4:0]   alu_flags;
  logic [M-1:0] A;
  logic [M-1:0] B;
  logic [1:0]   OpCode;
  logic [M-1:0] result_q;
  logic [4:0]   flags_q;
  logic         result_valid;
  logic [1:0]   stage;

  modport master (
    output data_in, load, undo, alu_result, alu_flags,
    input  A, B, OpCode, result_q, flags_q, result_valid, stage
  );

  modport slave (
    input  data_in, load, undo, alu_result, alu_flags,
    output A, B, OpCode, result_q, flags_q, result_valid, stage
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Loads A, B and the opcode from one switch bus on button edges, holds them on the ALU,
// and captures the ALU's result/flags one cycle after the operation is complete.
module alu_operand_sequencer #(
  parameter int M = 7
) (
  input logic                    clk,
  input logic                    reset,
  alu_operand_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    WAIT_OP = 2'b10,
    SHOW    = 2'b11
  } state_t;

  state_t       r_state, w_state_nxt;
  logic [M-1:0] r_a, w_a_nxt;
  logic [M-1:0] r_b, w_b_nxt;
  logic [1:0]   r_op, w_op_nxt;
  logic [M-1:0] r_result, w_result_nxt;
  logic [4:0]   r_flags, w_flags_nxt;
  logic         r_valid, w_valid_nxt;
  logic         r_load_prev;
  logic         r_undo_prev;

  logic w_load_rise;
  logic w_undo_rise;
  logic w_load_ev;
  logic w_undo_ev;

  // Prev registers reset high so a button held through reset is not seen as a press.
  assign w_load_rise = bus.load & ~r_load_prev;
  assign w_undo_rise = bus.undo & ~r_undo_prev;
  assign w_load_ev   = w_load_rise & ~w_undo_rise;
  assign w_undo_ev   = w_undo_rise & ~w_load_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= WAIT_A;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 2'b00;
      r_result    <= '0;
      r_flags     <= 5'b0;
      r_valid     <= 1'b0;
      r_load_prev <= 1'b1;
      r_undo_prev <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_op        <= w_op_nxt;
      r_result    <= w_result_nxt;
      r_flags     <= w_flags_nxt;
      r_valid     <= w_valid_nxt;
      r_load_prev <= bus.load;
      r_undo_prev <= bus.undo;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_op_nxt     = r_op;
    w_result_nxt = r_result;
    w_flags_nxt  = r_flags;
    w_valid_nxt  = r_valid;
    unique case (r_state)
      WAIT_A: begin
        if (w_load_ev) begin
          w_a_nxt     = bus.data_in;
          w_state_nxt = WAIT_B;
        end
      end
      WAIT_B: begin
        if (w_load_ev) begin
          w_b_nxt     = bus.data_in;
          w_state_nxt = WAIT_OP;
        end else if (w_undo_ev) begin
          w_state_nxt = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (w_load_ev) begin
          w_op_nxt    = bus.data_in[1:0];
          w_state_nxt = SHOW;
        end else if (w_undo_ev) begin
          w_state_nxt = WAIT_B;
        end
      end
      SHOW: begin
        // Capture waits one cycle in SHOW so the ALU has settled on the new opcode.
        if (w_load_ev) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = WAIT_A;
        end else if (w_undo_ev) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = WAIT_OP;
        end else if (!r_valid && !w_load_rise && !w_undo_rise) begin
          w_result_nxt = bus.alu_result;
          w_flags_nxt  = bus.alu_flags;
          w_valid_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = WAIT_A;
    endcase
  end

  assign bus.A            = r_a;
  assign bus.B            = r_b;
  assign bus.OpCode       = r_op;
  assign bus.result_q     = r_result;
  assign bus.flags_q      = r_flags;
  assign bus.result_valid = r_valid;
  assign bus.stage        = r_state;

endmodule
